sar_adc_reader: RTL
===================

Name: sar_adc_reader

Overview:
- Digital receive-side controller for the 10b SAR ADC macro.
- Generates the ADC sample clock and drives the comparator calibration code.
- Synchronises the macro's READY strobe into the system clock domain, captures the 11-bit result bus B[10:0] (B10 = MSB, first decision), and delivers samples over a valid/ready stream through a small FIFO.
- Reports overflow and missing-conversion errors.

Parameters:
- CLK_DIV, 16: system-clock cycles per ADC_CLK period; even, ≥4.
- SYNC_STAGES, 2: flops in the ADC_READY synchroniser; ≥2.
- FIFO_DEPTH, 4: sample FIFO entries; power of 2.
- SETTLE_CYC, 8: cycles ADC_CLK is held low after enable, while ADC_C settles.
- TIMEOUT_CYC, 64: cycles without a READY edge, while running, before TIMEOUT_ERR is set.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- EN  in  1  conversion enable, level.
- CAL_CODE  in  3  comparator calibration code.
- ERR_CLR  in  1  single-cycle clear of error status.
- ADC_B  in  11  ADC result bits B10..B0; asynchronous, stable from the READY rise until the next conversion completes.
- ADC_READY  in  1  ADC conversion-done strobe; asynchronous.
- ADC_CLK  out  1  ADC sample clock.
- ADC_C  out  3  calibration code to ADC inputs C1..C3 (bit0 = C1).
- OUT_DATA  out  11  sample.
- OUT_VALID  out  1  stream valid.
- OUT_READY  in  1  stream ready.
- OVERFLOW_CNT  out  8  dropped-sample count, saturating.
- TIMEOUT_ERR  out  1  sticky missing-READY flag.

Behaviour:
- Reset values: ADC_CLK=0, ADC_C=0, OUT_VALID=0, OUT_DATA=0, OVERFLOW_CNT=0, TIMEOUT_ERR=0. FIFO empty, FSM in OFF, synchroniser flops cleared.
- FSM states and transitions:
  - OFF → SETTLE when EN=1. On entry to SETTLE, ADC_C latches CAL_CODE.
  - SETTLE: ADC_CLK=0 for SETTLE_CYC cycles, then → RUN.
  - RUN: ADC_CLK toggles from a divider. High for CLK_DIV/2 cycles, then low for CLK_DIV/2 cycles; the first high phase begins on the first RUN cycle.
  - RUN → OFF when EN=0. ADC_CLK is forced to 0 on the next cycle. The divider and watchdog reset.
- ADC_C changes only on OFF→SETTLE. CAL_CODE changes during SETTLE or RUN are ignored.
- READY synchroniser: ADC_READY passes through SYNC_STAGES flops; a rising-edge detect follows the last flop. Each detected edge is one sample event.
- Capture:
  - ADC_B is registered on the sample-event cycle (cycle E).
  - ADC_B is registered again at E+1.
  - The E+1 value is pushed to the FIFO at E+1.
  - Latency from the ADC_READY rise to OUT_VALID is SYNC_STAGES+3 cycles maximum when the FIFO is empty.
- Sample events are processed in all states. A sample arriving in OFF (a late conversion) is still pushed.
- FIFO behaviour:
  - Data, count and order are first-in first-out.
  - OUT_DATA is the head entry; OUT_VALID = not empty.
  - A pop occurs when OUT_VALID & OUT_READY.
  - OUT_DATA is held stable while OUT_VALID=1 and OUT_READY=0.
- Full FIFO with push and no pop: the new sample is dropped. OVERFLOW_CNT increments, saturating at 255.
- Full FIFO with push and pop in the same cycle: both occur, with no overflow.
- Empty FIFO: OUT_READY is ignored.
- Watchdog:
  - Counts only in RUN.
  - Clears on every sample event and on entering RUN.
  - Reaching TIMEOUT_CYC sets TIMEOUT_ERR and restarts the count.
- ERR_CLR clears TIMEOUT_ERR and OVERFLOW_CNT. If a set or increment occurs in the same cycle as ERR_CLR, the set or increment wins: TIMEOUT_ERR=1, OVERFLOW_CNT=1.
- RST mid-operation: all state returns to reset values immediately. FIFO contents are lost.

Decomposition:
- Package sar_adc_pkg holds:
  - ADC_DATA_W=11 and CAL_W=3 constants.
  - The FSM state enum (OFF, SETTLE, RUN).
- One sub-module: sar_adc_sync_fifo. It is the parameterised synchronous FIFO, with push/pop, full/empty and count. The synchroniser is inline.

Test Plan:
1. Reset, then EN=1 with CAL_CODE=3'b101 → ADC_C=3'b101 one cycle after EN. ADC_CLK stays 0 for 8 cycles, then toggles with period 16. EN=0 → ADC_CLK=0 next cycle.
2. ADC_B=11'h5A3 with an ADC_READY rise, OUT_READY=1 → OUT_VALID within 5 cycles with OUT_DATA=11'h5A3, for one cycle. A second strobe with 11'h0FF yields the second sample, in order.
3. OUT_READY=0, six READY strobes with values 1–6 → OVERFLOW_CNT=2. Draining yields 1,2,3,4. ERR_CLR then sets OVERFLOW_CNT=0.
4. FIFO full, with a push and pop in the same cycle → no overflow; count stays 4; data order is preserved.
5. RUN with no READY for 64 cycles → TIMEOUT_ERR=1 at cycle 64 and stays 1. ERR_CLR clears it. Periodic strobes every 32 cycles keep TIMEOUT_ERR=0.
6. Assert RST while the FIFO holds 3 entries in RUN → OUT_VALID=0, ADC_CLK=0, ADC_C=0 immediately. After release, the FSM returns to OFF.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared constants and FSM state type for the SAR ADC receive controller.
package sar_adc_pkg;

    localparam int ADC_DATA_W = 11;
    localparam int CAL_W      = 3;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/sar_adc_sync_fifo.sv
// Small synchronous FIFO for captured ADC samples.
// Pop data is zero while empty so the stream output has a defined idle value.
module sar_adc_sync_fifo
    import sar_adc_pkg::*;
#(
    parameter int WIDTH = ADC_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write; no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sar_adc_reader.sv
// Receive-side controller for the 10b SAR ADC macro: sample clock generation,
// calibration code drive, READY synchronisation, result capture and streaming.
module sar_adc_reader
    import sar_adc_pkg::*;
#(
    parameter int CLK_DIV     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [CAL_W-1:0]      CAL_CODE,
    input  logic                  ERR_CLR,
    input  logic [ADC_DATA_W-1:0] ADC_B,
    input  logic                  ADC_READY,
    output logic                  ADC_CLK,
    output logic [CAL_W-1:0]      ADC_C,
    output logic [ADC_DATA_W-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [7:0]            OVERFLOW_CNT,
    output logic                  TIMEOUT_ERR
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int CW = $clog2(CLK_DIV);
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam int NW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DIV_HALF    = CW'(CLK_DIV / 2);
    localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT_CYC - 1);

    state_t                  state, state_nx;
    logic [SW-1:0]           settle_cnt, settle_nx;
    logic [CW-1:0]           div_cnt, div_nx;
    logic                    adc_clk_nx;
    logic [WW-1:0]           wd_cnt;
    logic                    timeout_set;

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    ready_prev;
    logic                    sample_ev;
    logic [ADC_DATA_W-1:0]   cap_q;
    logic                    push_q;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [NW-1:0]           fifo_count;
    logic                    pop;
    logic                    drop;

    // Next-state, settle timer and clock divider.
    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        div_nx    = div_cnt;
        case (state)
            OFF: begin
                settle_nx = '0;
                div_nx    = '0;
                if (EN) begin
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nx  = RUN;
                    settle_nx = '0;
                    div_nx    = '0;
                end else begin
                    settle_nx = settle_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!EN) begin
                    state_nx = OFF;
                    div_nx   = '0;
                end else if (div_cnt == DIV_LAST) begin
                    div_nx = '0;
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = OFF;
            end
        endcase
        // ADC_CLK is registered from the next-state view so it is glitch free
        // and the first high phase lines up with the first RUN cycle.
        adc_clk_nx = (state_nx == RUN) && (div_nx < DIV_HALF);
    end

    // FSM, counters, sample clock and calibration latch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= OFF;
            settle_cnt <= '0;
            div_cnt    <= '0;
            ADC_CLK    <= 1'b0;
            ADC_C      <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
            div_cnt    <= div_nx;
            ADC_CLK    <= adc_clk_nx;
            if (state == OFF && EN) begin
                ADC_C <= CAL_CODE;
            end
        end
    end

    // READY synchroniser with rising-edge detect after the last stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q     <= '0;
            ready_prev <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], ADC_READY};
            ready_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sample_ev = sync_q[SYNC_STAGES-1] && !ready_prev;

    // Result capture on the event cycle; the FIFO write next cycle re-registers it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cap_q  <= '0;
            push_q <= 1'b0;
        end else begin
            push_q <= sample_ev;
            if (sample_ev) begin
                cap_q <= ADC_B;
            end
        end
    end

    sar_adc_sync_fifo #(
        .WIDTH (ADC_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push_q),
        .push_data (cap_q),
        .pop       (pop),
        .pop_data  (OUT_DATA),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign OUT_VALID = (fifo_count != '0);
    assign pop       = OUT_READY && !fifo_empty;
    assign drop      = push_q && fifo_full && !pop;

    // Watchdog: counts RUN cycles between sample events.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt <= '0;
        end else if (state != RUN || sample_ev || wd_cnt == WD_LAST) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout_set = (state == RUN) && !sample_ev && (wd_cnt == WD_LAST);

    // Error status; a set or increment in the clear cycle takes priority.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TIMEOUT_ERR  <= 1'b0;
            OVERFLOW_CNT <= '0;
        end else begin
            if (timeout_set) begin
                TIMEOUT_ERR <= 1'b1;
            end else if (ERR_CLR) begin
                TIMEOUT_ERR <= 1'b0;
            end
            if (drop) begin
                if (ERR_CLR) begin
                    OVERFLOW_CNT <= 8'd1;
                end else if (OVERFLOW_CNT != 8'hFF) begin
                    OVERFLOW_CNT <= OVERFLOW_CNT + 8'd1;
                end
            end else if (ERR_CLR) begin
                OVERFLOW_CNT <= '0;
            end
        end
    end

endmodule
